// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: MMIO register offsets, STATUS bit layout and default MMIO base for dmem_ctrl.
package dmem_ctrl_pkg;

    localparam logic [31:0] DMEM_MMIO_BASE  = 32'hFFFF_0000;
    localparam int          DMEM_TXDATA_OFS = 0;
    localparam int          DMEM_STATUS_OFS = 4;
    localparam int          STAT_FULL_BIT   = 0;
    localparam int          STAT_OVF_BIT    = 1;
    localparam int          STAT_LEVEL_LSB  = 8;

    // Compares only the word part of the offset; byte-lane bits are ignored.
    function automatic logic ofs_hit(input logic [15:0] ofs, input int target);
        return ofs[15:2] == 14'(target >> 2);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with level output; push is accepted when full if a pop occurs in the same cycle.
module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full_o  = level_q == (AW+1)'(2**AW);
    assign empty_o = level_q == '0;
    assign level_o = level_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // Forced to zero when empty so the head never exposes stale storage.
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word RAM behind the CPU load/store ports, plus console TX queue MMIO when DMEM_MMIO_EN is defined.
// Loads are registered (one-cycle latency) and read-first against a same-cycle store.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int           W         = 32,
    parameter int           RAM_AW    = 10,
    parameter int           TXQ_AW    = 3,
    parameter logic [W-1:0] MMIO_BASE = DMEM_MMIO_BASE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en,
    input  logic [W-1:0] l_addr,
    output logic [W-1:0] l_data,
    input  logic         store_en,
    input  logic [W-1:0] s_addr,
    input  logic [W-1:0] s_data,
    output logic         tx_valid,
    output logic [7:0]   tx_data,
    input  logic         tx_ready,
    output logic         tx_overflow
);

    logic [W-1:0]      ram_q [2**RAM_AW];
    logic [RAM_AW-1:0] l_idx, s_idx;
    logic              l_mmio, s_mmio;
    logic [W-1:0]      mmio_rdata;
    logic [W-1:0]      l_data_q, l_data_d;
    logic              unused_ok;

    assign l_idx     = l_addr[RAM_AW+1:2];
    assign s_idx     = s_addr[RAM_AW+1:2];
    assign unused_ok = ^{l_addr, s_addr, s_data, tx_ready};

`ifdef DMEM_MMIO_EN
    logic [TXQ_AW:0] level;
    logic            full, empty, push, pop, ovf_clr;
    logic            ovf_q, ovf_d;

    assign l_mmio  = l_addr[W-1:16] == MMIO_BASE[W-1:16];
    assign s_mmio  = s_addr[W-1:16] == MMIO_BASE[W-1:16];
    assign push    = store_en && s_mmio && ofs_hit(s_addr[15:0], DMEM_TXDATA_OFS);
    assign ovf_clr = store_en && s_mmio && ofs_hit(s_addr[15:0], DMEM_STATUS_OFS) && s_data[STAT_OVF_BIT];
    assign pop     = tx_valid && tx_ready;
    // A dropped push sets overflow even when software clears it in the same cycle.
    assign ovf_d   = (push && full && !pop) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;

    always_comb begin
        mmio_rdata = '0;
        if (ofs_hit(l_addr[15:0], DMEM_STATUS_OFS)) begin
            mmio_rdata[STAT_LEVEL_LSB +: 8] = 8'(level);
            mmio_rdata[STAT_OVF_BIT]        = ovf_q;
            mmio_rdata[STAT_FULL_BIT]       = full;
        end
    end

    sync_fifo #(.DW(8), .AW(TXQ_AW)) u_txq (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (s_data[7:0]),
        .pop_i       (pop),
        .head_o      (tx_data),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (level)
    );

    assign tx_valid    = !empty;
    assign tx_overflow = ovf_q;

    always_ff @(posedge clk) begin
        ovf_q <= rst ? 1'b0 : ovf_d;
    end
`else
    assign l_mmio      = 1'b0;
    assign s_mmio      = 1'b0;
    assign mmio_rdata  = '0;
    assign tx_valid    = 1'b0;
    assign tx_data     = 8'h00;
    assign tx_overflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (store_en && !s_mmio && !rst) ram_q[s_idx] <= s_data;
    end

    assign l_data_d = load_en ? (l_mmio ? mmio_rdata : ram_q[l_idx]) : l_data_q;
    assign l_data   = l_data_q;

    always_ff @(posedge clk) begin
        l_data_q <= rst ? '0 : l_data_d;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed plus randomized stimulus checked against a word-array / byte-queue reference model.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0, store_en = 1'b0, tx_ready = 1'b0;
    logic [31:0] l_addr = '0, s_addr = '0, s_data = '0;
    logic [31:0] l_data;
    logic        tx_valid, tx_overflow;
    logic [7:0]  tx_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] mref [int];
    logic [7:0]  q [$];
    logic        ovf_m = 1'b0;
    logic [31:0] l_exp = '0;

    dmem_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .l_addr      (l_addr),
        .l_data      (l_data),
        .store_en    (store_en),
        .s_addr      (s_addr),
        .s_data      (s_data),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_overflow (tx_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic is_mmio(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
        return a[31:16] == 16'hFFFF;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (is_mmio(a)) begin
            if (a[15:0] >= 16'h4 && a[15:0] <= 16'h7)
                return {16'h0, 8'(q.size()), 6'h0, ovf_m, q.size() == 8};
            return 32'h0;
        end
        return mref[widx(a)];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic ld, input logic [31:0] la,
                       input logic st, input logic [31:0] sa, input logic [31:0] sd,
                       input logic rdy);
        logic pop, psh, drop;
        rst = r; load_en = ld; l_addr = la;
        store_en = st; s_addr = sa; s_data = sd; tx_ready = rdy;
        if (r) begin
            l_exp = '0;
            q.delete();
            ovf_m = 1'b0;
        end else begin
            if (ld) l_exp = model_read(la);
            pop  = q.size() != 0 && rdy;
            psh  = st && is_mmio(sa) && sa[15:0] <= 16'h3;
            drop = psh && q.size() == 8 && !pop;
            if (st && !is_mmio(sa)) mref[widx(sa)] = sd;
            if (pop) void'(q.pop_front());
            if (psh && !drop) q.push_back(sd[7:0]);
            if (st && is_mmio(sa) && sa[15:0] >= 16'h4 && sa[15:0] <= 16'h7 && sd[1]) ovf_m = 1'b0;
            if (drop) ovf_m = 1'b1;
        end
        @(posedge clk);
        #1;
        check("l_data", l_data, l_exp);
        check("tx_valid", {31'h0, tx_valid}, {31'h0, q.size() != 0});
        check("tx_data", {24'h0, tx_data}, {24'h0, q.size() != 0 ? q[0] : 8'h00});
        check("tx_overflow", {31'h0, tx_overflow}, {31'h0, ovf_m});
    endtask

    localparam logic [31:0] TXD = 32'hFFFF_0000;
    localparam logic [31:0] STS = 32'hFFFF_0004;

    initial begin
        logic [31:0] la, sa;
        // reset with a load pending: l_data must stay 0
        cyc(1, 1, 32'h0, 0, 0, 0, 0);
        cyc(1, 1, 32'h0, 0, 0, 0, 0);
        check("reset_l_data", l_data, 32'h0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 32'(i * 4), $urandom, 0);
        // store then load, including an aliased address
        cyc(0, 0, 0, 1, 32'h40, 32'hDEADBEEF, 0);
        cyc(0, 1, 32'h40, 0, 0, 0, 0);
        check("load_0x40", l_data, 32'hDEADBEEF);
        cyc(0, 1, 32'h1040, 0, 0, 0, 0);
        check("alias_0x1040", l_data, 32'hDEADBEEF);
        // read-first on same-index load/store
        cyc(0, 0, 0, 1, 32'h80, 32'h5, 0);
        cyc(0, 1, 32'h80, 1, 32'h80, 32'h1, 0);
        check("read_first_old", l_data, 32'h5);
        cyc(0, 1, 32'h80, 0, 0, 0, 0);
        check("read_first_new", l_data, 32'h1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("hold_l_data", l_data, 32'h1);
`ifdef DMEM_MMIO_EN
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1, TXD, 32'h41 + 32'(i), 0);
        cyc(0, 1, STS, 0, 0, 0, 0);
        check("status_full_ovf", l_data, 32'h0000_0803);
        for (int i = 0; i < 8; i++) begin
            check("drain_order", {24'h0, tx_data}, 32'h41 + 32'(i));
            cyc(0, 0, 0, 0, 0, 0, 1);
        end
        check("drained_empty", {31'h0, tx_valid}, 32'h0);
        cyc(0, 0, 0, 1, STS, 32'h2, 0);
        check("ovf_cleared", {31'h0, tx_overflow}, 32'h0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, TXD, 32'h30 + 32'(i), 0);
        cyc(0, 0, 0, 1, TXD, 32'h5A, 1);
        cyc(0, 1, STS, 0, 0, 0, 0);
        check("full_push_pop", l_data, 32'h0000_0801);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, TXD, 32'h77, 0);
        cyc(1, 0, 0, 1, 32'h80, 32'h99, 0);
        check("rst_drops_valid", {31'h0, tx_valid}, 32'h0);
        cyc(0, 1, STS, 0, 0, 0, 0);
        check("status_after_rst", l_data, 32'h0);
        cyc(0, 1, 32'h80, 0, 0, 0, 0);
        check("rst_store_blocked", l_data, 32'h1);
`else
        cyc(0, 0, 0, 1, STS, 32'h1234_5678, 0);
        cyc(0, 1, 32'h4, 0, 0, 0, 1);
        check("no_mmio_alias", l_data, 32'h1234_5678);
`endif
        // randomized traffic over initialised RAM words and the MMIO window
        for (int n = 0; n < 600; n++) begin
            la = $urandom;
            la[11:2] = 10'($urandom_range(0, 15));
            if (la[31:16] == 16'hFFFF) la[31] = 1'b0;
            if ($urandom_range(0, 2) == 0) la = {16'hFFFF, 14'($urandom_range(0, 3)), 2'($urandom)};
            sa = $urandom;
            sa[11:2] = 10'($urandom_range(0, 15));
            if (sa[31:16] == 16'hFFFF) sa[31] = 1'b0;
            if ($urandom_range(0, 1) == 0) sa = {16'hFFFF, 14'($urandom_range(0, 3)), 2'($urandom)};
            cyc($urandom_range(0, 99) == 0, 1'($urandom), la, 1'($urandom), sa, $urandom,
                $urandom_range(0, 2) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
